// File: rtl/gray_downsample_2x2.sv
// Averages each 2x2 block of an 8-bit pixel stream into one pixel plus a half-resolution write address.
// Define GRAY_DOWNSAMPLE_ROUND_EN to round half up instead of truncating the average.
module gray_downsample_2x2 #(
  parameter int IN_WIDTH  = 320,
  parameter int IN_HEIGHT = 240,
  parameter int ADDR_W    = 15
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [7:0]        pixel_in,
  input  logic              valid_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  output logic [7:0]        pixel_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid_out,
  output logic              frame_done_out
);

  localparam int HALF_W = IN_WIDTH / 2;
  localparam int HALF_H = IN_HEIGHT / 2;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HALF_W * HALF_H - 1);
`ifdef GRAY_DOWNSAMPLE_ROUND_EN
  localparam logic [9:0] ROUND_BIAS = 10'd2;
`else
  localparam logic [9:0] ROUND_BIAS = 10'd0;
`endif

  typedef enum logic [1:0] {
    WAIT_EVEN = 2'd0,
    FILL      = 2'd1,
    MERGE     = 2'd2
  } state_t;

  state_t            state;
  logic [9:0]        row_v;

  // Horizontal pair latch
  logic              half;
  logic [7:0]        lat_pix;
  logic [10:0]       lat_h;
  logic [9:0]        lat_v;

  // Stage 1: pair sum headed for the line buffer (write in FILL, read in MERGE)
  logic              s1_fill;
  logic              s1_merge;
  logic [IDX_W-1:0]  s1_idx;
  logic [8:0]        s1_sum;
  logic [ADDR_W-1:0] s1_addr;

  // Stage 2: line-buffer read data meets the odd-row pair sum
  logic              s2_valid;
  logic [8:0]        s2_sum;
  logic [ADDR_W-1:0] s2_addr;
  logic [8:0]        rd_q;

  logic [8:0]        linebuf [HALF_W];

  logic              accept;
  logic              pair_hit;
  logic [8:0]        pair_sum;
  logic [ADDR_W-1:0] blk_addr;
  logic [9:0]        total;
  logic [7:0]        avg;

  assign accept   = valid_in && (hcount_in < 11'(IN_WIDTH)) && (vcount_in < 10'(IN_HEIGHT));
  assign pair_hit = accept && hcount_in[0] && half &&
                    (lat_v == vcount_in) && (lat_h == hcount_in - 11'd1);
  assign pair_sum = {1'b0, lat_pix} + {1'b0, pixel_in};
  assign blk_addr = ADDR_W'(32'(vcount_in >> 1) * 32'(HALF_W) + 32'(hcount_in >> 1));
  assign total    = {1'b0, rd_q} + {1'b0, s2_sum};
  assign avg      = 8'((total + ROUND_BIAS) >> 2);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= WAIT_EVEN;
      row_v          <= '0;
      half           <= 1'b0;
      lat_pix        <= '0;
      lat_h          <= '0;
      lat_v          <= '0;
      s1_fill        <= 1'b0;
      s1_merge       <= 1'b0;
      s1_idx         <= '0;
      s1_sum         <= '0;
      s1_addr        <= '0;
      s2_valid       <= 1'b0;
      s2_sum         <= '0;
      s2_addr        <= '0;
      pixel_out      <= '0;
      addr_out       <= '0;
      valid_out      <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      if (accept) begin
        if (!hcount_in[0]) begin
          half    <= 1'b1;
          lat_pix <= pixel_in;
          lat_h   <= hcount_in;
          lat_v   <= vcount_in;
        end else begin
          half <= 1'b0;
        end

        case (state)
          WAIT_EVEN: begin
            if (!vcount_in[0]) begin
              state <= FILL;
              row_v <= vcount_in;
            end
          end
          FILL: begin
            if (vcount_in == row_v + 10'd1) state <= MERGE;
            else if (vcount_in[0])          state <= WAIT_EVEN;
            else                            row_v <= vcount_in;
          end
          MERGE: begin
            if (!vcount_in[0]) begin
              state <= FILL;
              row_v <= vcount_in;
            end else if (vcount_in != row_v + 10'd1) begin
              state <= WAIT_EVEN;
            end
          end
          default: state <= WAIT_EVEN;
        endcase
      end

      // A hit means the even half was the previous accepted pixel on the same row,
      // so the row transition already happened there and the current state applies.
      s1_fill  <= pair_hit && (state == FILL);
      s1_merge <= pair_hit && (state == MERGE);
      s1_idx   <= hcount_in[IDX_W:1];
      s1_sum   <= pair_sum;
      s1_addr  <= blk_addr;

      s2_valid <= s1_merge;
      s2_sum   <= s1_sum;
      s2_addr  <= s1_addr;

      valid_out      <= s2_valid;
      frame_done_out <= s2_valid && (s2_addr == LAST_ADDR);
      if (s2_valid) begin
        pixel_out <= avg;
        addr_out  <= s2_addr;
      end
    end
  end

  // NOTE: the line buffer and its read register carry no reset; stale entries are never
  // consumed because a MERGE row can only follow a FILL row that rewrote them.
  always_ff @(posedge clk_in) begin
    if (s1_fill)       linebuf[s1_idx] <= s1_sum;
    else if (s1_merge) rd_q            <= linebuf[s1_idx];
  end

endmodule

// File: tb/tb_gray_downsample_2x2.sv
// Bench for gray_downsample_2x2: block-vector table, latency and mid-row reset sequences,
// and randomized rows scored against a 2x2 block-average model of the image.
module tb_gray_downsample_2x2;

  localparam int IN_W = 320;
  localparam int IN_H = 240;
  localparam int AW   = 15;
  localparam int HW   = IN_W / 2;
  localparam int LAST = HW * (IN_H / 2) - 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [7:0]    pixel_in;
  logic          valid_in;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic [7:0]    pixel_out;
  logic [AW-1:0] addr_out;
  logic          valid_out;
  logic          frame_done_out;

  int n_checks = 0;
  int n_errors = 0;
  int stray_fd = 0;

  typedef struct {
    logic [7:0]    pix;
    logic [AW-1:0] addr;
    logic          fd;
  } out_t;

  typedef struct {
    int         bx;
    int         by;
    logic [7:0] p00;
    logic [7:0] p10;
    logic [7:0] p01;
    logic [7:0] p11;
    logic [7:0] exp_t;
    logic [7:0] exp_r;
  } vec_t;

  out_t       got_q[$];
  out_t       exp_q[$];
  logic [7:0] img [IN_H][IN_W];
  vec_t       vecs [10];

  always #5 clk_in = ~clk_in;

  gray_downsample_2x2 #(
    .IN_WIDTH (IN_W),
    .IN_HEIGHT(IN_H),
    .ADDR_W   (AW)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .pixel_in      (pixel_in),
    .valid_in      (valid_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .pixel_out     (pixel_out),
    .addr_out      (addr_out),
    .valid_out     (valid_out),
    .frame_done_out(frame_done_out)
  );

  always @(negedge clk_in) begin
    if (valid_out) got_q.push_back('{pixel_out, addr_out, frame_done_out});
    if (frame_done_out && !valid_out) stray_fd++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    int t;
    t = 32'(a) + 32'(b) + 32'(c) + 32'(d);
`ifdef GRAY_DOWNSAMPLE_ROUND_EN
    t = t + 2;
`endif
    return 8'(t / 4);
  endfunction

  task automatic send(input logic [7:0] p, input int h, input int v, input logic vld);
    @(negedge clk_in);
    pixel_in  = p;
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    valid_in  = vld;
  endtask

  task automatic idle(input int n);
    @(negedge clk_in);
    valid_in = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic send_junk();
    case ($urandom_range(2))
      0:       send(8'($urandom), int'($urandom_range(IN_W - 1)), int'($urandom_range(IN_H - 1)), 1'b0);
      1:       send(8'($urandom), int'($urandom_range(2047, IN_W)), int'($urandom_range(IN_H - 1)), 1'b1);
      default: send(8'($urandom), int'($urandom_range(IN_W - 1)), int'($urandom_range(1023, IN_H)), 1'b1);
    endcase
  endtask

  task automatic send_span(input int v, input int h0, input int h1, input int junk_pct);
    for (int h = h0; h < h1; h++) begin
      if (junk_pct > 0 && int'($urandom_range(99)) < junk_pct) send_junk();
      send(img[v][h], h, v, 1'b1);
    end
  endtask

  task automatic fill_row(input int v, input logic rnd, input logic [7:0] val);
    for (int h = 0; h < IN_W; h++) img[v][h] = rnd ? 8'($urandom) : val;
  endtask

  // Expected blocks 0..nx-1 of the row pair (ev, ev+1), straight from the image.
  task automatic expect_pair(input int ev, input int nx);
    for (int x = 0; x < nx; x++) begin
      int   a;
      out_t o;
      a      = (ev / 2) * HW + x;
      o.pix  = avg4(img[ev][2*x], img[ev][2*x+1], img[ev+1][2*x], img[ev+1][2*x+1]);
      o.addr = AW'(a);
      o.fd   = (a == LAST);
      exp_q.push_back(o);
    end
  endtask

  task automatic compare_queues(input string name);
    int e0;
    check({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      e0 = n_errors;
      check($sformatf("%s[%0d] pix", name, i),  32'(got_q[i].pix),  32'(exp_q[i].pix));
      check($sformatf("%s[%0d] addr", name, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s[%0d] fd", name, i),   32'(got_q[i].fd),   32'(exp_q[i].fd));
      if (n_errors != e0) break;
    end
    check({name, " stray frame_done"}, 32'(stray_fd), 0);
    stray_fd = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] e;
    int         a;

    rst_n_in  = 1'b0;
    valid_in  = 1'b0;
    pixel_in  = '0;
    hcount_in = '0;
    vcount_in = '0;

    vecs[0] = '{0,   0,   8'd10,  8'd11,  8'd12,  8'd14,  8'd11,  8'd12};
    vecs[1] = '{1,   0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    vecs[2] = '{2,   1,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    vecs[3] = '{3,   1,   8'd0,   8'd0,   8'd0,   8'd1,   8'd0,   8'd0};
    vecs[4] = '{4,   2,   8'd0,   8'd0,   8'd1,   8'd1,   8'd0,   8'd1};
    vecs[5] = '{5,   2,   8'd1,   8'd2,   8'd3,   8'd4,   8'd2,   8'd3};
    vecs[6] = '{6,   3,   8'd255, 8'd0,   8'd255, 8'd0,   8'd127, 8'd128};
    vecs[7] = '{7,   3,   8'd100, 8'd101, 8'd102, 8'd103, 8'd101, 8'd102};
    vecs[8] = '{8,   4,   8'd254, 8'd255, 8'd255, 8'd255, 8'd254, 8'd255};
    vecs[9] = '{159, 119, 8'd200, 8'd201, 8'd202, 8'd203, 8'd201, 8'd202};

    // Reset state
    @(negedge clk_in);
    check("reset valid_out",      32'(valid_out), 0);
    check("reset frame_done_out", 32'(frame_done_out), 0);
    check("reset pixel_out",      32'(pixel_out), 0);
    check("reset addr_out",       32'(addr_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Latency: strobe appears exactly two edges after the (1,1) pixel is sampled
`ifdef GRAY_DOWNSAMPLE_ROUND_EN
    e = vecs[0].exp_r;
`else
    e = vecs[0].exp_t;
`endif
    send(vecs[0].p00, 0, 0, 1'b1);
    send(vecs[0].p10, 1, 0, 1'b1);
    send(vecs[0].p01, 0, 1, 1'b1);
    send(vecs[0].p11, 1, 1, 1'b1);
    @(negedge clk_in);
    valid_in = 1'b0;
    check("latency valid at N",   32'(valid_out), 0);
    @(negedge clk_in);
    check("latency valid at N+1", 32'(valid_out), 0);
    @(negedge clk_in);
    check("latency valid at N+2", 32'(valid_out), 1);
    check("latency pixel_out",    32'(pixel_out), 32'(e));
    check("latency addr_out",     32'(addr_out), 0);
    idle(3);
    got_q.delete();

    // Table of single blocks, including the last block of the frame
    for (int i = 0; i < 10; i++) begin
`ifdef GRAY_DOWNSAMPLE_ROUND_EN
      e = vecs[i].exp_r;
`else
      e = vecs[i].exp_t;
`endif
      a = vecs[i].by * HW + vecs[i].bx;
      send(vecs[i].p00, 2 * vecs[i].bx,     2 * vecs[i].by,     1'b1);
      send(vecs[i].p10, 2 * vecs[i].bx + 1, 2 * vecs[i].by,     1'b1);
      send(vecs[i].p01, 2 * vecs[i].bx,     2 * vecs[i].by + 1, 1'b1);
      send(vecs[i].p11, 2 * vecs[i].bx + 1, 2 * vecs[i].by + 1, 1'b1);
      idle(4);
      check($sformatf("vec%0d count", i), 32'(got_q.size()), 1);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d pix", i),  32'(got_q[0].pix), 32'(e));
        check($sformatf("vec%0d addr", i), 32'(got_q[0].addr), 32'(a));
        check($sformatf("vec%0d fd", i),   32'(got_q[0].fd), 32'(a == LAST));
      end
      got_q.delete();
    end
    check("table stray frame_done", 32'(stray_fd), 0);
    stray_fd = 0;

    // Constant 0x80 row pair
    fill_row(0, 1'b0, 8'h80);
    fill_row(1, 1'b0, 8'h80);
    send_span(0, 0, IN_W, 0);
    send_span(1, 0, IN_W, 0);
    idle(4);
    expect_pair(0, HW);
    compare_queues("const80");

    // Rows 0,1,2 then jump to 5, resume with 6,7
    foreach (vecs[k]) begin end
    for (int v = 0; v < 8; v++) fill_row(v, 1'b1, 8'h00);
    send_span(0, 0, IN_W, 0);
    send_span(1, 0, IN_W, 0);
    send_span(2, 0, IN_W, 0);
    send_span(5, 0, IN_W, 0);
    send_span(6, 0, IN_W, 0);
    send_span(7, 0, IN_W, 0);
    idle(4);
    expect_pair(0, HW);
    expect_pair(6, HW);
    compare_queues("jump");

    // One-cycle reset halfway through row 1
    for (int v = 0; v < 4; v++) fill_row(v, 1'b1, 8'h00);
    send_span(0, 0, IN_W, 0);
    send_span(1, 0, HW, 0);
    idle(3);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    check("midreset valid_out",      32'(valid_out), 0);
    check("midreset frame_done_out", 32'(frame_done_out), 0);
    check("midreset pixel_out",      32'(pixel_out), 0);
    check("midreset addr_out",       32'(addr_out), 0);
    rst_n_in = 1'b1;
    send_span(1, HW, IN_W, 0);
    send_span(2, 0, IN_W, 0);
    send_span(3, 0, IN_W, 0);
    idle(4);
    expect_pair(0, HW / 2);
    expect_pair(2, HW);
    compare_queues("midreset");

    // Ignored cycles (valid low, h or v out of range) interleaved with random rows
    for (int v = 2; v < 6; v++) fill_row(v, 1'b1, 8'h00);
    for (int v = 2; v < 6; v++) send_span(v, 0, IN_W, 30);
    idle(4);
    expect_pair(2, HW);
    expect_pair(4, HW);
    compare_queues("junk");

    // Full random frame
    for (int v = 0; v < IN_H; v++) fill_row(v, 1'b1, 8'h00);
    for (int v = 0; v < IN_H; v++) send_span(v, 0, IN_W, 0);
    idle(4);
    for (int v = 0; v < IN_H; v += 2) expect_pair(v, HW);
    compare_queues("frame");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
